// File: rtl/prio_grant_arbiter.sv
// Fixed-priority (highest index wins) arbiter with a registered one-hot grant and index.
// A hold timeout masks the revoked requester once so lower indices get a turn.
module prio_grant_arbiter #(
  parameter int N        = 8,
  parameter int IW       = 3,
  parameter int MAX_HOLD = 16,
  parameter int CW       = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  input  logic          en,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          gnt_valid,
  output logic          timeout
);

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_GAP} state_t;

  localparam logic [CW-1:0] HOLD_LIM = CW'(MAX_HOLD);
  localparam logic [CW-1:0] HOLD_SAT = '1;

  state_t        r_state, w_state;
  logic [N-1:0]  r_gnt, w_gnt;
  logic [IW-1:0] r_gnt_idx, w_gnt_idx;
  logic          r_gnt_valid, w_gnt_valid;
  logic          r_timeout, w_timeout;
  logic [CW-1:0] r_hold_cnt, w_hold_cnt;
  logic [N-1:0]  r_mask, w_mask;
  logic [N-1:0]  w_elig;
  logic [IW-1:0] w_win;

  function automatic logic [IW-1:0] f_high_idx(input logic [N-1:0] v);
    logic [IW-1:0] idx;
    idx = '0;
    for (int i = 0; i < N; i++) begin
      if (v[i]) idx = IW'(i);
    end
    return idx;
  endfunction

  assign w_elig = req & ~r_mask;
  assign w_win  = f_high_idx(w_elig);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_gnt       <= '0;
      r_gnt_idx   <= '0;
      r_gnt_valid <= 1'b0;
      r_timeout   <= 1'b0;
      r_hold_cnt  <= '0;
      r_mask      <= '0;
    end else begin
      r_state     <= w_state;
      r_gnt       <= w_gnt;
      r_gnt_idx   <= w_gnt_idx;
      r_gnt_valid <= w_gnt_valid;
      r_timeout   <= w_timeout;
      r_hold_cnt  <= w_hold_cnt;
      r_mask      <= w_mask;
    end
  end

  always_comb begin
    w_state     = r_state;
    w_gnt       = r_gnt;
    w_gnt_idx   = r_gnt_idx;
    w_gnt_valid = r_gnt_valid;
    w_timeout   = 1'b0;
    w_hold_cnt  = r_hold_cnt;
    w_mask      = r_mask;
    case (r_state)
      S_IDLE: begin
        w_gnt       = '0;
        w_gnt_valid = 1'b0;
        if (en && (|w_elig)) begin
          w_gnt       = N'(1) << w_win;
          w_gnt_idx   = w_win;
          w_gnt_valid = 1'b1;
          w_hold_cnt  = CW'(1);
          w_mask      = '0;
          w_state     = S_GRANT;
        end else if (en && (|req)) begin
          // Everyone still asking is masked: drop the mask so they compete next edge.
          w_mask = '0;
        end
      end
      S_GRANT: begin
        if (!req[r_gnt_idx]) begin
          w_gnt       = '0;
          w_gnt_valid = 1'b0;
          w_state     = S_GAP;
        end else if ((MAX_HOLD != 0) && (r_hold_cnt == HOLD_LIM)) begin
          w_gnt       = '0;
          w_gnt_valid = 1'b0;
          w_timeout   = 1'b1;
          w_mask      = N'(1) << r_gnt_idx;
          w_state     = S_GAP;
        end else if (r_hold_cnt != HOLD_SAT) begin
          w_hold_cnt = r_hold_cnt + CW'(1);
        end
      end
      S_GAP: begin
        w_gnt       = '0;
        w_gnt_valid = 1'b0;
        w_state     = S_IDLE;
      end
      default: begin
        w_gnt       = '0;
        w_gnt_valid = 1'b0;
        w_state     = S_IDLE;
      end
    endcase
  end

  assign gnt       = r_gnt;
  assign gnt_idx   = r_gnt_idx;
  assign gnt_valid = r_gnt_valid;
  assign timeout   = r_timeout;

endmodule

// File: tb/tb_prio_grant_arbiter.sv
// Scoreboard bench for prio_grant_arbiter (MAX_HOLD=4): a cycle model pushes expected
// outputs at each sampling edge, and they are popped and compared on the falling edge.
module tb_prio_grant_arbiter;

  localparam int N  = 8;
  localparam int IW = 3;
  localparam int MH = 4;
  localparam int CW = 3;

  logic          clk;
  logic          rst_n;
  logic [N-1:0]  req;
  logic          en;
  logic [N-1:0]  gnt;
  logic [IW-1:0] gnt_idx;
  logic          gnt_valid;
  logic          timeout;

  prio_grant_arbiter #(.N(N), .IW(IW), .MAX_HOLD(MH), .CW(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .en        (en),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0]  gnt;
    logic [IW-1:0] idx;
    logic          vld;
    logic          to;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // reference model state: 0 idle, 1 granted, 2 gap
  int           m_st;
  int           m_cnt;
  logic [N-1:0] m_mask;
  exp_t         m_out;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st   = 0;
    m_cnt  = 0;
    m_mask = '0;
    m_out  = '0;
  endtask

  task automatic model_edge(input logic [N-1:0] r, input logic e);
    logic [N-1:0] elig;
    int           top;
    m_out.to = 1'b0;
    if (m_st == 0) begin
      elig = r & ~m_mask;
      top  = -1;
      for (int i = N - 1; i >= 0; i--) if (elig[i] && top < 0) top = i;
      if (e && top >= 0) begin
        m_out.gnt = '0;
        m_out.gnt[top] = 1'b1;
        m_out.idx = IW'(top);
        m_out.vld = 1'b1;
        m_cnt  = 1;
        m_mask = '0;
        m_st   = 1;
      end else begin
        if (e && r != 0) m_mask = '0;
        m_out.gnt = '0;
        m_out.vld = 1'b0;
      end
    end else if (m_st == 1) begin
      if (r[m_out.idx] == 1'b0) begin
        m_out.gnt = '0;
        m_out.vld = 1'b0;
        m_st = 2;
      end else if (m_cnt == MH) begin
        m_mask = '0;
        m_mask[m_out.idx] = 1'b1;
        m_out.gnt = '0;
        m_out.vld = 1'b0;
        m_out.to  = 1'b1;
        m_st = 2;
      end else if (m_cnt < (1 << CW) - 1) begin
        m_cnt++;
      end
    end else begin
      m_out.gnt = '0;
      m_out.vld = 1'b0;
      m_st = 0;
    end
  endtask

  task automatic step(input logic [N-1:0] r, input logic e);
    exp_t x;
    req = r;
    en  = e;
    @(posedge clk);
    model_edge(r, e);
    exp_q.push_back(m_out);
    @(negedge clk);
    if (exp_q.size() == 0) begin
      chk("sb_empty", 32'd0, 32'd1);
    end else begin
      x = exp_q.pop_front();
      chk("gnt", 32'(gnt), 32'(x.gnt));
      chk("gnt_idx", 32'(gnt_idx), 32'(x.idx));
      chk("gnt_valid", 32'(gnt_valid), 32'(x.vld));
      chk("timeout", 32'(timeout), 32'(x.to));
      chk("onehot0", 32'($onehot0(gnt)), 32'd1);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req   = '0;
    en    = 1'b0;
    model_reset();
    #2;
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_idx", 32'(gnt_idx), 32'd0);
    chk("rst_vld", 32'(gnt_valid), 32'd0);
    chk("rst_to", 32'(timeout), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // T1: highest set bit wins
    step(8'b0010_0110, 1'b1);
    chk("T1_gnt", 32'(gnt), 32'h20);
    chk("T1_idx", 32'(gnt_idx), 32'd5);

    // T2: no preemption by req[7]; it wins after release and two idle cycles
    step(8'hA6, 1'b1);
    chk("T2_hold", 32'(gnt), 32'h20);
    step(8'hA6, 1'b1);
    step(8'h86, 1'b1);
    chk("T2_gap1", 32'(gnt), 32'h00);
    step(8'h86, 1'b1);
    chk("T2_gap2", 32'(gnt), 32'h00);
    step(8'h86, 1'b1);
    chk("T2_gnt7", 32'(gnt), 32'h80);
    chk("T2_idx7", 32'(gnt_idx), 32'd7);
    step(8'h00, 1'b1);
    step(8'h00, 1'b1);

    // T3: timeout after MAX_HOLD cycles lets requester 0 in
    for (int i = 0; i < MH; i++) begin
      step(8'h81, 1'b1);
      chk("T3_hold80", 32'(gnt), 32'h80);
    end
    step(8'h81, 1'b1);
    chk("T3_timeout", 32'(timeout), 32'd1);
    step(8'h81, 1'b1);
    chk("T3_to_pulse", 32'(timeout), 32'd0);
    step(8'h81, 1'b1);
    chk("T3_gnt01", 32'(gnt), 32'h01);
    step(8'h80, 1'b1);
    step(8'h80, 1'b1);
    step(8'h80, 1'b1);
    chk("T3_back80", 32'(gnt), 32'h80);
    step(8'h00, 1'b1);
    step(8'h00, 1'b1);

    // T4: lone requester sees an extra mask-clear cycle after its timeout
    for (int i = 0; i < MH; i++) step(8'h80, 1'b1);
    step(8'h80, 1'b1);
    chk("T4_timeout", 32'(timeout), 32'd1);
    step(8'h80, 1'b1);
    step(8'h80, 1'b1);
    chk("T4_zero3", 32'(gnt), 32'h00);
    step(8'h80, 1'b1);
    chk("T4_regrant", 32'(gnt), 32'h80);
    step(8'h00, 1'b1);
    step(8'h00, 1'b1);

    // T5: en gates new grants only
    for (int i = 0; i < 10; i++) step(8'hFF, 1'b0);
    chk("T5_blocked", 32'(gnt), 32'h00);
    step(8'hFF, 1'b1);
    chk("T5_gnt80", 32'(gnt), 32'h80);
    step(8'hFF, 1'b0);
    step(8'hFF, 1'b0);
    chk("T5_kept", 32'(gnt), 32'h80);
    step(8'h7F, 1'b0);
    chk("T5_release", 32'(gnt), 32'h00);
    step(8'h00, 1'b0);
    step(8'h00, 1'b0);

    // T6: asynchronous reset mid-grant
    step(8'h20, 1'b1);
    chk("T6_pre", 32'(gnt), 32'h20);
    #2;
    rst_n = 1'b0;
    #1;
    chk("T6_gnt", 32'(gnt), 32'd0);
    chk("T6_vld", 32'(gnt_valid), 32'd0);
    chk("T6_idx", 32'(gnt_idx), 32'd0);
    chk("T6_to", 32'(timeout), 32'd0);
    model_reset();
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    step(8'h04, 1'b1);
    chk("T6_after", 32'(gnt), 32'h04);

    // random traffic against the model
    for (int i = 0; i < 200; i++) begin
      step(N'($urandom_range(0, 255)) & N'($urandom_range(0, 255)),
           1'($urandom_range(0, 3) != 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
